// File: rtl/snl_pkg.sv
// Shared constants, winner encodings and the snake/ladder table for the snakes_ladders engine.
package snl_pkg;

    localparam int unsigned MAX_POS = 100;

    localparam logic [1:0] WIN_P1   = 2'b00;
    localparam logic [1:0] WIN_P2   = 2'b01;
    localparam logic [1:0] WIN_NONE = 2'b10;

    // Feedback taps b7, b5, b4, b3 of the die LFSR.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [6:0] jump(input logic [6:0] sq);
        logic [6:0] dst;
        case (sq)
            7'd4:    dst = 7'd14;
            7'd9:    dst = 7'd31;
            7'd21:   dst = 7'd42;
            7'd28:   dst = 7'd84;
            7'd51:   dst = 7'd67;
            7'd72:   dst = 7'd91;
            7'd80:   dst = 7'd99;
            7'd17:   dst = 7'd7;
            7'd54:   dst = 7'd34;
            7'd62:   dst = 7'd19;
            7'd64:   dst = 7'd60;
            7'd87:   dst = 7'd36;
            7'd93:   dst = 7'd73;
            7'd95:   dst = 7'd75;
            7'd98:   dst = 7'd79;
            default: dst = sq;
        endcase
        return dst;
    endfunction

endpackage

// File: rtl/snl_dice.sv
// Pseudo-random die: 8-bit Fibonacci LFSR, value = (lfsr mod 6) + 1 from the current register.
module snl_dice
    import snl_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [2:0] die
);

    logic [7:0] lfsr_q;
    logic [7:0] rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else if (enable) begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_comb begin
        rem = lfsr_q % 8'd6;
        die = rem[2:0] + 3'd1;
    end

endmodule

// File: rtl/snakes_ladders.sv
// Two-player snakes and ladders engine; one move per clock, freezes on the first exact hit of MAX_POS.
// Optional macro SNL_BONUS_SIX_EN: a roll of 6 that moves keeps the turn with the same player.
module snakes_ladders
    import snl_pkg::*;
#(
    parameter logic [7:0]  SEED    = 8'hA5,
    parameter int unsigned MAX_POS = snl_pkg::MAX_POS
) (
    input  logic       clk,
    input  logic       reset,
    output logic [6:0] pos1,
    output logic [6:0] pos2,
    output logic [1:0] winner
);

    logic [6:0] pos1_q, pos1_d;
    logic [6:0] pos2_q, pos2_d;
    logic [1:0] winner_q, winner_d;
    logic       turn_q, turn_d;   // 0 = player 1, 1 = player 2
    logic [2:0] die;
    logic [6:0] cur;
    logic [7:0] tmp;
    logic [6:0] landed;
    logic       moved;

    snl_dice #(
        .SEED(SEED)
    ) u_dice (
        .clk   (clk),
        .reset (reset),
        .enable(winner_q == WIN_NONE),
        .die   (die)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos1_q   <= 7'd0;
            pos2_q   <= 7'd0;
            winner_q <= WIN_NONE;
            turn_q   <= 1'b0;
        end else begin
            pos1_q   <= pos1_d;
            pos2_q   <= pos2_d;
            winner_q <= winner_d;
            turn_q   <= turn_d;
        end
    end

    always_comb begin
        cur      = turn_q ? pos2_q : pos1_q;
        tmp      = {1'b0, cur} + {5'd0, die};
        moved    = (tmp <= 8'(MAX_POS));
        landed   = jump(tmp[6:0]);
        pos1_d   = pos1_q;
        pos2_d   = pos2_q;
        winner_d = winner_q;
        turn_d   = turn_q;
        if (winner_q == WIN_NONE) begin
            if (moved) begin
                if (turn_q) pos2_d = landed;
                else        pos1_d = landed;
                if (landed == 7'(MAX_POS)) winner_d = turn_q ? WIN_P2 : WIN_P1;
            end
`ifdef SNL_BONUS_SIX_EN
            turn_d = (moved && die == 3'd6) ? turn_q : ~turn_q;
`else
            turn_d = ~turn_q;
`endif
        end
    end

    assign pos1   = pos1_q;
    assign pos2   = pos2_q;
    assign winner = winner_q;

endmodule

// File: tb/tb_snakes_ladders.sv
// Directed and lockstep-model bench for snakes_ladders (honours SNL_BONUS_SIX_EN when defined).
module tb_snakes_ladders;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] pos1, pos2;
    logic [1:0] winner;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_lfsr;
    logic [6:0] m_p1, m_p2;
    logic [1:0] m_win;
    logic       m_turn;

    always #5 clk = ~clk;

    snakes_ladders #(
        .SEED   (8'hA5),
        .MAX_POS(100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pos1  (pos1),
        .pos2  (pos2),
        .winner(winner)
    );

    function automatic int ref_jump(input int sq);
        case (sq)
            4: return 14;   9: return 31;  21: return 42;  28: return 84;
            51: return 67; 72: return 91;  80: return 99;
            17: return 7;  54: return 34;  62: return 19;  64: return 60;
            87: return 36; 93: return 73;  95: return 75;  98: return 79;
            default: return sq;
        endcase
    endfunction

    task automatic model_reset();
        m_lfsr = 8'hA5;
        m_p1   = 7'd0;
        m_p2   = 7'd0;
        m_win  = 2'b10;
        m_turn = 1'b0;
    endtask

    task automatic model_step();
        int  die;
        int  t;
        int  np;
        bit  mv;
        bit  keep;
        if (m_win != 2'b10) return;
        die = int'(m_lfsr) % 6 + 1;
        t   = (m_turn ? int'(m_p2) : int'(m_p1)) + die;
        mv  = (t <= 100);
        if (mv) begin
            np = ref_jump(t);
            if (m_turn) m_p2 = 7'(np);
            else        m_p1 = 7'(np);
            if (np == 100) m_win = m_turn ? 2'b01 : 2'b00;
        end
        keep = 1'b0;
`ifdef SNL_BONUS_SIX_EN
        keep = mv && (die == 6);
`endif
        if (!keep) m_turn = ~m_turn;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++;
        if (pos1 !== 7'd0)   begin n_fail++; $display("FAIL reset_held_pos1 got %0d want 0", pos1); end
        n_checks++;
        if (pos2 !== 7'd0)   begin n_fail++; $display("FAIL reset_held_pos2 got %0d want 0", pos2); end
        n_checks++;
        if (winner !== 2'b10) begin n_fail++; $display("FAIL reset_held_winner got %b want 10", winner); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (pos1 !== 7'd0)   begin n_fail++; $display("FAIL reset_rel_pos1 got %0d want 0", pos1); end
        n_checks++;
        if (pos2 !== 7'd0)   begin n_fail++; $display("FAIL reset_rel_pos2 got %0d want 0", pos2); end
        n_checks++;
        if (winner !== 2'b10) begin n_fail++; $display("FAIL reset_rel_winner got %b want 10", winner); end
    endtask

    // die 4 takes player 1 to the 4->14 ladder, then die 3 moves player 2 to 3
    task automatic test_first_moves();
        @(posedge clk); #1;
        n_checks++;
        if (pos1 !== 7'd14)  begin n_fail++; $display("FAIL first_pos1 got %0d want 14", pos1); end
        n_checks++;
        if (pos2 !== 7'd0)   begin n_fail++; $display("FAIL first_pos2 got %0d want 0", pos2); end
        n_checks++;
        if (winner !== 2'b10) begin n_fail++; $display("FAIL first_winner got %b want 10", winner); end
        @(posedge clk); #1;
        n_checks++;
        if (pos2 !== 7'd3)   begin n_fail++; $display("FAIL second_pos2 got %0d want 3", pos2); end
        n_checks++;
        if (pos1 !== 7'd14)  begin n_fail++; $display("FAIL second_pos1 got %0d want 14", pos1); end
    endtask

    task automatic test_lockstep();
        logic [6:0] prev1, prev2;
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            prev1 = pos1;
            prev2 = pos2;
            @(posedge clk);
            model_step();
            #1;
            n_checks++;
            if (pos1 !== m_p1) begin n_fail++; $display("FAIL lock_pos1 cyc %0d got %0d want %0d", i, pos1, m_p1); end
            n_checks++;
            if (pos2 !== m_p2) begin n_fail++; $display("FAIL lock_pos2 cyc %0d got %0d want %0d", i, pos2, m_p2); end
            n_checks++;
            if (winner !== m_win) begin n_fail++; $display("FAIL lock_winner cyc %0d got %b want %b", i, winner, m_win); end
            n_checks++;
            if (pos1 > 7'd100 || pos2 > 7'd100) begin
                n_fail++; $display("FAIL lock_range cyc %0d got %0d/%0d want <=100", i, pos1, pos2);
            end
            n_checks++;
            if (pos1 !== prev1 && pos2 !== prev2) begin
                n_fail++; $display("FAIL lock_one_mover cyc %0d got both changed want one", i);
            end
        end
    endtask

    task automatic test_win_freeze();
        bit         done = 1'b0;
        logic [6:0] h1, h2;
        logic [1:0] hw;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(posedge clk);
            model_step();
            #1;
            if (winner !== 2'b10) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL win_timeout got winner %b want a winner within 20000 cycles", winner);
            return;
        end
        n_checks++;
        if (winner !== m_win) begin n_fail++; $display("FAIL win_code got %b want %b", winner, m_win); end
        n_checks++;
        if (winner === 2'b00 && pos1 !== 7'd100) begin n_fail++; $display("FAIL win_pos1 got %0d want 100", pos1); end
        else if (winner === 2'b01 && pos2 !== 7'd100) begin n_fail++; $display("FAIL win_pos2 got %0d want 100", pos2); end
        n_checks++;
        if (pos1 !== m_p1 || pos2 !== m_p2) begin
            n_fail++; $display("FAIL win_positions got %0d/%0d want %0d/%0d", pos1, pos2, m_p1, m_p2);
        end
        h1 = pos1; h2 = pos2; hw = winner;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (pos1 !== h1 || pos2 !== h2 || winner !== hw) begin
                n_fail++;
                $display("FAIL freeze cyc %0d got %0d/%0d/%b want %0d/%0d/%b", i, pos1, pos2, winner, h1, h2, hw);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (pos1 !== 7'd0 || pos2 !== 7'd0 || winner !== 2'b10) begin
            n_fail++; $display("FAIL midreset_async got %0d/%0d/%b want 0/0/10", pos1, pos2, winner);
        end
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (pos1 !== 7'd14 || pos2 !== 7'd0) begin
            n_fail++; $display("FAIL midreset_first got %0d/%0d want 14/0", pos1, pos2);
        end
        @(posedge clk); #1;
        n_checks++;
        if (pos1 !== 7'd14 || pos2 !== 7'd3) begin
            n_fail++; $display("FAIL midreset_second got %0d/%0d want 14/3", pos1, pos2);
        end
    endtask

    // the player the model says is idle must not move; covers bonus-six turn retention
    task automatic test_turn_order();
        logic [6:0] prev1, prev2;
        logic       active;
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            prev1  = pos1;
            prev2  = pos2;
            active = m_turn;
            @(posedge clk);
            model_step();
            #1;
            n_checks++;
            if (!active && pos2 !== prev2) begin
                n_fail++; $display("FAIL turn_p2_idle cyc %0d got %0d want %0d", i, pos2, prev2);
            end else if (active && pos1 !== prev1) begin
                n_fail++; $display("FAIL turn_p1_idle cyc %0d got %0d want %0d", i, pos1, prev1);
            end
            n_checks++;
            if (pos1 !== m_p1 || pos2 !== m_p2) begin
                n_fail++; $display("FAIL turn_pos cyc %0d got %0d/%0d want %0d/%0d", i, pos1, pos2, m_p1, m_p2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_moves();
        test_lockstep();
        test_win_freeze();
        test_mid_reset();
        test_turn_order();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
